rps_round_judge: RTL and testbench
==================================

# rps_round_judge

Round referee for the rock-paper-scissors arcade game. It runs a three-stage countdown after a start press and latches the player's button choice. At the end of the countdown it draws a pseudo-random machine move, then presents the round outcome on a 2-bit result code. It is the producer of the round-result stream consumed by the consecutive-win tracker. Its result output idles at the draw code, so the tracker sees a change only on the single cycle a round resolves.

## Interface
- STAGE_CYCLES, default 25_000_000: clock cycles per countdown stage (0.5 s at 50 MHz); minimum 1.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low; clock clk.
- start  in  1  raw start button, asynchronous level.
- player_btn  in  3  raw move buttons, asynchronous levels; bit0 rock, bit1 paper, bit2 scissors.
- result  out  2  round result: 2'b00 lose, 2'b01 draw/idle, 2'b11 win; 2'b10 never driven.
- result_valid  out  1  one-cycle pulse, coincident with the resolved result.
- player_move  out  2  latched player move: 2'b00 none, 2'b01 rock, 2'b10 paper, 2'b11 scissors.
- machine_move  out  2  machine move, same encoding.
- countdown  out  3  countdown lights.
- busy  out  1  high in COUNT, REVEAL and SHOW.

## Operation
- **Input synchronisation:** start and player_btn each pass through a 2-flop synchroniser. All logic below uses the synchronised copies (start_s, btn_s) plus one-cycle-delayed copies for edge detection.
- **States:**
  - IDLE: entered from reset.
  - COUNT: entered from IDLE or DONE on a start_s rising edge.
    - Entry clears player_move and machine_move and zeroes the stage counter.
    - Lasts exactly 3*STAGE_CYCLES cycles, then goes to REVEAL.
  - REVEAL: one cycle. It samples the machine move, computes the outcome and goes to SHOW.
  - SHOW: one cycle. result is set to the outcome and result_valid=1. Then goes to DONE.
  - DONE: player_move and machine_move hold; the next start_s rising edge goes to COUNT.
- **Ignored inputs:** start edges in COUNT, REVEAL and SHOW are ignored.
- **Countdown lights:**
  - 3'b111 during the first stage of COUNT, 3'b011 during the second, 3'b001 during the third.
  - 3'b000 in all other states.
- **Player latch:** only in COUNT, and only on the first cycle where btn_s is one-hot and the previous btn_s was 3'b000.
  - The first qualifying press wins; all later presses in the round are ignored.
  - Multi-hot patterns never latch.
  - A button held from before COUNT entry never latches until it is released and pressed again.
- **Machine move:** an 8-bit Fibonacci LFSR steps every cycle in all states.
  - Polynomial x^8+x^6+x^5+x^4+1; shift left, feedback into bit0 = q[7]^q[5]^q[4]^q[3].
  - Seed 8'h01 on reset; never all-zero.
  - In REVEAL: machine_move = (lfsr mod 3) + 1.
- **Outcome** (evaluated in this order):
  1. player_move = 00: lose.
  2. Equal moves: draw.
  3. Rock beats scissors, paper beats rock, scissors beats paper → win; otherwise lose.
- **result outside SHOW:** always 2'b01, so a downstream FSM stepping every cycle holds its state.
- **Reset:** when reset is low at a clock edge, from any state, next cycle:
  - state=IDLE, lfsr=8'h01, stage counter 0;
  - result=2'b01, result_valid=0, player_move=00, machine_move=00, countdown=000, busy=0;
  - synchroniser and edge-history flops cleared to 0.
  - A reset mid-COUNT therefore produces no result_valid pulse.

## Timing
- All outputs are registered; no combinational path from inputs.
- Start latency: raw start rising at edge n is visible as start_s at edge n+2; COUNT (countdown=111, busy=1) is registered at edge n+3.
- The same 2-cycle synchroniser latency applies to player_btn.
- A press latched on the final COUNT cycle counts for the round.
- REVEAL begins exactly 3*STAGE_CYCLES cycles after COUNT entry; result_valid rises one cycle later and lasts exactly one cycle.
- Round length from COUNT entry to result_valid: 3*STAGE_CYCLES+1 cycles.
- Stage counter width is $clog2(STAGE_CYCLES); it wraps to 0 at each stage boundary.

## Structure
- **Package rps_pkg:**
  - move codes MOVE_NONE/ROCK/PAPER/SCISSORS;
  - result codes RES_LOSE=2'b00, RES_DRAW=2'b01, RES_WIN=2'b11;
  - state enum IDLE/COUNT/REVEAL/SHOW/DONE;
  - LFSR seed constant.
- **Sub-module rps_move_lfsr:** 8-bit LFSR with sync active-low reset; outputs the current value and the mod-3 move.
- The top level holds the synchronisers, edge detection, FSM, stage counter and outcome logic.

## Test plan
All scenarios use STAGE_CYCLES=4; the bench models the LFSR to predict machine_move.
- **Reset:** reset low 3 cycles, then high → result=01, result_valid=0, moves=00, countdown=000, busy=0; result stays 01 while idle.
- **Paper round:** start pulse, paper press (3'b010) in stage 2 → countdown 111/011/001 for 4 cycles each, player_move=10; on result_valid, result=11 if machine rock, 01 if paper, 00 if scissors; the next cycle returns result to 01.
- **No press:** start with no button → player_move=00, result=00 on the single valid cycle regardless of machine_move.
- **Press filtering:** press 3'b011, then 3'b100, then release and press 3'b001 → only scissors latched (player_move=11).
- **Held button:** rock held from IDLE through all of COUNT → no latch, result=00.
- **Abort and ignored start:** reset low mid-COUNT → IDLE outputs next cycle and no result_valid. In a new round, a start pulse during COUNT → countdown sequence unchanged and exactly one result_valid.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors round referee.
// Move codes, result codes, FSM states, LFSR seed and the outcome rule.
// Pure definitions; no state, no timing.
package rps_pkg;

  localparam logic [1:0] MOVE_NONE     = 2'b00;
  localparam logic [1:0] MOVE_ROCK     = 2'b01;
  localparam logic [1:0] MOVE_PAPER    = 2'b10;
  localparam logic [1:0] MOVE_SCISSORS = 2'b11;

  // 2'b10 is deliberately unused so the tracker can treat bit0 as "not lost".
  localparam logic [1:0] RES_LOSE = 2'b00;
  localparam logic [1:0] RES_DRAW = 2'b01;
  localparam logic [1:0] RES_WIN  = 2'b11;

  localparam logic [7:0] LFSR_SEED = 8'h01;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COUNT  = 3'd1,
    REVEAL = 3'd2,
    SHOW   = 3'd3,
    DONE   = 3'd4
  } state_t;

  // No press always loses, even against the machine; ties are checked before
  // the beats-relation so equal moves never fall through to lose.
  function automatic logic [1:0] round_outcome(input logic [1:0] player,
                                               input logic [1:0] machine);
    logic [1:0] res;
    if (player == MOVE_NONE) begin
      res = RES_LOSE;
    end else if (player == machine) begin
      res = RES_DRAW;
    end else if ((player == MOVE_ROCK     && machine == MOVE_SCISSORS) ||
                 (player == MOVE_PAPER    && machine == MOVE_ROCK)     ||
                 (player == MOVE_SCISSORS && machine == MOVE_PAPER)) begin
      res = RES_WIN;
    end else begin
      res = RES_LOSE;
    end
    return res;
  endfunction

endpackage

// File: rtl/rps_move_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) and its mod-3 move.
// Latency: value is the register itself; move is a combinational decode of it.
// No backpressure: steps on every clock outside reset.
module rps_move_lfsr
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] value,
  output logic [1:0] move
);

  logic [7:0] lfsr_q;

  // Shift left with XOR feedback into bit0; seed is non-zero so the register never locks up.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign value = lfsr_q;
  // Remainder is 0..2, so the move is always ROCK, PAPER or SCISSORS, never NONE.
  assign move  = 2'(lfsr_q % 8'd3) + 2'd1;

endmodule

// File: rtl/rps_round_judge.sv
// Round referee: start-triggered 3-stage countdown, player latch, machine draw, result.
// Latency: start to COUNT 3 cycles; COUNT entry to result_valid 3*STAGE_CYCLES+1 cycles.
// No backpressure: result_valid is a single-cycle pulse the consumer must take.
module rps_round_judge
  import rps_pkg::*;
#(
  parameter int STAGE_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] player_btn,
  output logic [1:0] result,
  output logic       result_valid,
  output logic [1:0] player_move,
  output logic [1:0] machine_move,
  output logic [2:0] countdown,
  output logic       busy
);

  localparam int              CW       = (STAGE_CYCLES > 1) ? $clog2(STAGE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(STAGE_CYCLES - 1);

  logic          start_m, start_s, start_d;
  logic [2:0]    btn_m, btn_s, btn_d;
  logic          start_rise;
  logic          btn_press;
  logic [1:0]    btn_move;
  state_t        state, state_nxt;
  logic [CW-1:0] stage_cnt;
  logic [1:0]    stage_idx;
  logic          stage_end;
  logic [7:0]    lfsr_value_unused;
  logic [1:0]    lfsr_move;

  rps_move_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr_value_unused),
    .move  (lfsr_move)
  );

  // Two-flop synchronisers plus one-cycle history for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_m <= 1'b0;
      start_s <= 1'b0;
      start_d <= 1'b0;
      btn_m   <= 3'b000;
      btn_s   <= 3'b000;
      btn_d   <= 3'b000;
    end else begin
      start_m <= start;
      start_s <= start_m;
      start_d <= start_s;
      btn_m   <= player_btn;
      btn_s   <= btn_m;
      btn_d   <= btn_s;
    end
  end

  assign start_rise = start_s & ~start_d;
  assign stage_end  = (stage_cnt == CNT_LAST);

  // Decode a fresh one-hot press; a button held over from the previous cycle does not qualify.
  always_comb begin
    btn_move = MOVE_NONE;
    case (btn_s)
      3'b001:  btn_move = MOVE_ROCK;
      3'b010:  btn_move = MOVE_PAPER;
      3'b100:  btn_move = MOVE_SCISSORS;
      default: btn_move = MOVE_NONE;
    endcase
    btn_press = (btn_move != MOVE_NONE) && (btn_d == 3'b000);
  end

  // Next-state: start is only honoured from IDLE or DONE; COUNT ends after its third stage.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_rise) state_nxt = COUNT;
      COUNT:      if (stage_end && stage_idx == 2'd2) state_nxt = REVEAL;
      REVEAL:     state_nxt = SHOW;
      SHOW:       state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State register with all outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      stage_cnt    <= '0;
      stage_idx    <= 2'd0;
      result       <= RES_DRAW;
      result_valid <= 1'b0;
      player_move  <= MOVE_NONE;
      machine_move <= MOVE_NONE;
      countdown    <= 3'b000;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      // Result idles at draw so a downstream streak FSM holds its state between rounds.
      result       <= RES_DRAW;
      result_valid <= 1'b0;
      busy         <= (state_nxt == COUNT) || (state_nxt == REVEAL) || (state_nxt == SHOW);
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            player_move  <= MOVE_NONE;
            machine_move <= MOVE_NONE;
            stage_cnt    <= '0;
            stage_idx    <= 2'd0;
            countdown    <= 3'b111;
          end
        end
        COUNT: begin
          // First qualifying press of the round wins, including one on the final COUNT cycle.
          if (player_move == MOVE_NONE && btn_press) begin
            player_move <= btn_move;
          end
          if (stage_end) begin
            stage_cnt <= '0;
            stage_idx <= stage_idx + 2'd1;
            case (stage_idx)
              2'd0:    countdown <= 3'b011;
              2'd1:    countdown <= 3'b001;
              default: countdown <= 3'b000;
            endcase
          end else begin
            stage_cnt <= stage_cnt + 1'b1;
          end
        end
        REVEAL: begin
          machine_move <= lfsr_move;
          result       <= round_outcome(player_move, lfsr_move);
          result_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rps_round_judge.sv
// Self-checking bench for rps_round_judge with STAGE_CYCLES=4.
// Table of round records plus hand-written reset and abort sequences.
// Machine move predicted from an independent LFSR model driven by the same reset.
module tb_rps_round_judge;

  localparam int STAGE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] player_btn;
  logic [1:0] result;
  logic       result_valid;
  logic [1:0] player_move;
  logic [1:0] machine_move;
  logic [2:0] countdown;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rps_round_judge #(.STAGE_CYCLES(STAGE)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .player_btn   (player_btn),
    .result       (result),
    .result_valid (result_valid),
    .player_move  (player_move),
    .machine_move (machine_move),
    .countdown    (countdown),
    .busy         (busy)
  );

  // Reference LFSR; m_lfsr_prev holds the value that was current before the latest edge.
  logic [7:0] m_lfsr;
  logic [7:0] m_lfsr_prev;
  always @(posedge clk) begin
    if (!reset) begin
      m_lfsr      <= 8'h01;
      m_lfsr_prev <= 8'h01;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  // Which machine move each player move defeats.
  function automatic logic [1:0] victim_of(input logic [1:0] p);
    case (p)
      2'b01:   return 2'b11;
      2'b10:   return 2'b01;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_result(input logic [1:0] p, input logic [1:0] m);
    if (p == 2'b00)           return 2'b00;
    if (p == m)               return 2'b01;
    if (victim_of(p) == m)    return 2'b11;
    return 2'b00;
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic wait_entry(input string nm, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (countdown == 3'b111) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: countdown never reached 111 within 10 cycles, got %0h", nm, countdown);
    end
  endtask

  typedef struct packed {
    logic [11:0][2:0] btn;        // raw buttons driven on COUNT cycle c
    logic             pre_hold;   // rock held from before the start press
    logic [4:0]       start_at;   // COUNT cycle carrying an extra start pulse (31 = none)
    logic [1:0]       exp_player; // hand-derived latched move
  } round_t;

  round_t rounds [0:6];

  task automatic run_round(input int idx);
    round_t     r;
    bit         ok;
    int         vld_cnt;
    logic [2:0] exp_cd;
    logic [7:0] tmp;
    logic [1:0] exp_mm;
    r      = rounds[idx];
    exp_mm = 2'b00;
    player_btn = r.pre_hold ? 3'b001 : 3'b000;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_entry($sformatf("r%0d_entry", idx), ok);
    if (!ok) return;
    vld_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (result_valid) vld_cnt++;
      if (c < 12) begin
        exp_cd = (c < 4) ? 3'b111 : (c < 8) ? 3'b011 : 3'b001;
        check($sformatf("r%0d_countdown_c%0d", idx, c), 8'(countdown), 8'(exp_cd));
        if (c == 0) check($sformatf("r%0d_busy_count", idx), 8'(busy), 8'd1);
        if (c == 6) check($sformatf("r%0d_result_idle_count", idx), 8'(result), 8'h01);
      end else if (c == 12) begin
        check($sformatf("r%0d_countdown_reveal", idx), 8'(countdown), 8'h00);
        check($sformatf("r%0d_busy_reveal", idx), 8'(busy), 8'd1);
        check($sformatf("r%0d_valid_reveal", idx), 8'(result_valid), 8'd0);
      end else if (c == 13) begin
        tmp    = m_lfsr_prev % 8'd3;
        exp_mm = tmp[1:0] + 2'd1;
        check($sformatf("r%0d_valid_show", idx), 8'(result_valid), 8'd1);
        check($sformatf("r%0d_player_move", idx), 8'(player_move), 8'(r.exp_player));
        check($sformatf("r%0d_machine_move", idx), 8'(machine_move), 8'(exp_mm));
        check($sformatf("r%0d_result", idx), 8'(result), 8'(exp_result(r.exp_player, exp_mm)));
      end else if (c == 14) begin
        check($sformatf("r%0d_result_after", idx), 8'(result), 8'h01);
        check($sformatf("r%0d_valid_after", idx), 8'(result_valid), 8'd0);
        check($sformatf("r%0d_busy_done", idx), 8'(busy), 8'd0);
        check($sformatf("r%0d_player_hold", idx), 8'(player_move), 8'(r.exp_player));
        check($sformatf("r%0d_machine_hold", idx), 8'(machine_move), 8'(exp_mm));
      end
      player_btn = (c < 12) ? r.btn[c] : 3'b000;
      start      = (c == int'(r.start_at));
      @(negedge clk);
    end
    start = 1'b0;
    check($sformatf("r%0d_valid_pulses", idx), 8'(vld_cnt), 8'd1);
  endtask

  initial begin
    bit ok;
    int vld_cnt;
    reset      = 1'b0;
    start      = 1'b0;
    player_btn = 3'b000;

    // Reset held for three edges.
    repeat (3) @(negedge clk);
    check("rst_result", 8'(result), 8'h01);
    check("rst_valid", 8'(result_valid), 8'd0);
    check("rst_player", 8'(player_move), 8'd0);
    check("rst_machine", 8'(machine_move), 8'd0);
    check("rst_countdown", 8'(countdown), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("idle_result_%0d", k), 8'(result), 8'h01);
      check($sformatf("idle_busy_%0d", k), 8'(busy), 8'd0);
    end

    for (int i = 0; i < 7; i++) begin
      rounds[i]          = '0;
      rounds[i].start_at = 5'd31;
    end
    // 0: paper pressed in stage 2
    rounds[0].btn[4] = 3'b010; rounds[0].btn[5] = 3'b010; rounds[0].exp_player = 2'b10;
    // 1: no press
    rounds[1].exp_player = 2'b00;
    // 2: multi-hot, release, scissors, release, rock -> scissors only
    rounds[2].btn[0] = 3'b011; rounds[2].btn[2] = 3'b100; rounds[2].btn[4] = 3'b001;
    rounds[2].exp_player = 2'b11;
    // 3: multi-hot sliding to one-hot without release -> nothing
    rounds[3].btn[1] = 3'b110; rounds[3].btn[2] = 3'b010; rounds[3].btn[3] = 3'b010;
    rounds[3].exp_player = 2'b00;
    // 4: rock held from IDLE through COUNT
    rounds[4].pre_hold = 1'b1;
    for (int c = 0; c < 12; c++) rounds[4].btn[c] = 3'b001;
    rounds[4].exp_player = 2'b00;
    // 5: scissors pulse landing on the final COUNT cycle
    rounds[5].btn[9] = 3'b100; rounds[5].exp_player = 2'b11;
    // 6: rock early, extra start pulse mid-COUNT
    rounds[6].btn[0] = 3'b001; rounds[6].start_at = 5'd3; rounds[6].exp_player = 2'b01;

    for (int i = 0; i < 6; i++) run_round(i);

    // Abort: reset low mid-COUNT after a latched paper press.
    player_btn = 3'b000;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_entry("abort_entry", ok);
    if (ok) begin
      player_btn = 3'b010;
      repeat (5) @(negedge clk);
      check("abort_pre_player", 8'(player_move), 8'h02);
      check("abort_pre_countdown", 8'(countdown), 8'h03);
      reset = 1'b0;
      @(negedge clk);
      check("abort_countdown", 8'(countdown), 8'd0);
      check("abort_busy", 8'(busy), 8'd0);
      check("abort_result", 8'(result), 8'h01);
      check("abort_player", 8'(player_move), 8'd0);
      check("abort_machine", 8'(machine_move), 8'd0);
      reset      = 1'b1;
      player_btn = 3'b000;
      vld_cnt    = 0;
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (result_valid) vld_cnt++;
      end
      check("abort_no_valid", 8'(vld_cnt), 8'd0);
      check("abort_idle_countdown", 8'(countdown), 8'd0);
    end

    run_round(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
